kernel3_gmem_a_m_axi_rd_sched: RTL and testbench

Read-burst scheduler for one m_axi read channel. It takes beat-granular read requests from the kernel and splits them into AXI AR bursts. Each burst is capped by BURST_MAX and must not cross a 4 KB boundary. A burst is issued only when the downstream read-data FIFO (FIFO_DEPTH entries) has guaranteed room for every beat, using a credit counter, and only while the number of in-flight bursts is below MAX_OUTSTANDING.

---
 rtl/kernel3_gmem_a_m_axi_rd_sched.sv | 147 ++++++++++++++
 tb/tb_kernel3_gmem_a_m_axi_rd_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel3_gmem_a_m_axi_rd_sched.sv
// Read-burst scheduler for one m_axi read channel: splits beat-granular requests into AR
// bursts capped by BURST_MAX and 4 KB pages, gated by FIFO credits and an outstanding limit.
module kernel3_gmem_a_m_axi_rd_sched #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned LEN_WIDTH       = 32,
    parameter int unsigned DATA_BYTES      = 4,
    parameter int unsigned BURST_MAX       = 16,
    parameter int unsigned FIFO_DEPTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned CRED_W         = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clk_en,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LEN_WIDTH-1:0]  i_req_len,
    output logic                  o_ar_valid,
    input  logic                  i_ar_ready,
    output logic [ADDR_WIDTH-1:0] o_ar_addr,
    output logic [7:0]            o_ar_len,
    input  logic                  i_burst_done,
    input  logic                  i_credit_ret,
    output logic [CRED_W-1:0]     o_credits,
    output logic [OUT_W-1:0]      o_outstanding,
    output logic                  o_busy
);

    localparam int unsigned ADDR_SHIFT = $clog2(DATA_BYTES);
    localparam int unsigned BLEN_W     = 9;

    typedef enum logic [1:0] {StIdle, StCalc, StWait, StIssue} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [BLEN_W-1:0]     r_blen;
    logic                  r_ar_valid;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [CRED_W-1:0]     r_credits;
    logic [OUT_W-1:0]      r_outstanding;

    logic [ADDR_WIDTH-1:0] w_req_addr_al;
    logic [12:0]           w_page_beats;
    logic [12:0]           w_cap;
    logic [BLEN_W-1:0]     w_blen;
    logic                  w_gate;
    logic                  w_issue;
    logic [LEN_WIDTH-1:0]  w_rem_next;
    logic [CRED_W-1:0]     w_credits_next;
    logic [OUT_W-1:0]      w_out_next;

    assign w_req_addr_al = i_req_addr & ~ADDR_WIDTH'(DATA_BYTES - 1);

    // Beats left before the next 4 KB boundary; cur_addr is always beat-aligned.
    assign w_page_beats = (13'h1000 - {1'b0, r_cur_addr[11:0]}) >> ADDR_SHIFT;
    assign w_cap        = (w_page_beats < 13'(BURST_MAX)) ? w_page_beats : 13'(BURST_MAX);
    assign w_blen       = (r_remaining < LEN_WIDTH'(w_cap)) ? BLEN_W'(r_remaining)
                                                            : BLEN_W'(w_cap);

    assign w_gate     = (32'(r_credits) >= 32'(r_blen)) &&
                        (32'(r_outstanding) < MAX_OUTSTANDING);
    assign w_issue    = (r_state == StIssue) && i_ar_ready;
    assign w_rem_next = r_remaining - LEN_WIDTH'(r_blen);

    always_comb begin
        w_credits_next = r_credits;
        if (w_issue) begin
            w_credits_next = r_credits - CRED_W'(r_blen);
        end
        // A return can only overflow when nothing was issued this cycle.
        if (i_credit_ret && (w_credits_next != CRED_W'(FIFO_DEPTH))) begin
            w_credits_next = w_credits_next + CRED_W'(1);
        end
    end

    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue) begin
            w_out_next = w_out_next + OUT_W'(1);
        end
        if (i_burst_done && (r_outstanding != '0)) begin
            w_out_next = w_out_next - OUT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_blen        <= '0;
            r_ar_valid    <= 1'b0;
            r_ar_addr     <= '0;
            r_ar_len      <= '0;
            r_credits     <= CRED_W'(FIFO_DEPTH);
            r_outstanding <= '0;
        end else if (i_clk_en) begin
            r_credits     <= w_credits_next;
            r_outstanding <= w_out_next;
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_cur_addr  <= w_req_addr_al;
                        r_remaining <= i_req_len;
                        if (i_req_len != '0) begin
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    r_blen  <= w_blen;
                    r_state <= StWait;
                end
                StWait: begin
                    if (w_gate) begin
                        r_ar_addr  <= r_cur_addr;
                        r_ar_len   <= 8'(r_blen - BLEN_W'(1));
                        r_ar_valid <= 1'b1;
                        r_state    <= StIssue;
                    end
                end
                StIssue: begin
                    if (i_ar_ready) begin
                        r_ar_valid  <= 1'b0;
                        r_cur_addr  <= r_cur_addr + (ADDR_WIDTH'(r_blen) << ADDR_SHIFT);
                        r_remaining <= w_rem_next;
                        r_state     <= (w_rem_next == '0) ? StIdle : StCalc;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready   = (r_state == StIdle);
    assign o_busy        = (r_state != StIdle);
    assign o_ar_valid    = r_ar_valid;
    assign o_ar_addr     = r_ar_addr;
    assign o_ar_len      = r_ar_len;
    assign o_credits     = r_credits;
    assign o_outstanding = r_outstanding;

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_rd_sched.sv
// Directed bench for the read-burst scheduler: a vector table of request splits plus
// hand-written sequences for latency, credit stall, outstanding cap, clk_en and reset.
module tb_kernel3_gmem_a_m_axi_rd_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, clk_en;
    logic        req_valid, ar_ready, burst_done, credit_ret;
    logic [63:0] req_addr;
    logic [31:0] req_len;
    logic        req_ready, ar_valid, busy;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [5:0]  credits;
    logic [3:0]  outstanding;

    logic        b_req_valid, b_ar_ready, b_burst_done, b_credit_ret;
    logic [63:0] b_req_addr;
    logic [31:0] b_req_len;
    logic        b_req_ready, b_ar_valid, b_busy;
    logic [63:0] b_ar_addr;
    logic [7:0]  b_ar_len;
    logic [5:0]  b_credits;
    logic [1:0]  b_outstanding;

    kernel3_gmem_a_m_axi_rd_sched u_dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_clk_en      (clk_en),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr    (req_addr),
        .i_req_len     (req_len),
        .o_ar_valid    (ar_valid),
        .i_ar_ready    (ar_ready),
        .o_ar_addr     (ar_addr),
        .o_ar_len      (ar_len),
        .i_burst_done  (burst_done),
        .i_credit_ret  (credit_ret),
        .o_credits     (credits),
        .o_outstanding (outstanding),
        .o_busy        (busy)
    );

    kernel3_gmem_a_m_axi_rd_sched #(
        .BURST_MAX       (4),
        .MAX_OUTSTANDING (2)
    ) u_dut_cap (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_clk_en      (clk_en),
        .i_req_valid   (b_req_valid),
        .o_req_ready   (b_req_ready),
        .i_req_addr    (b_req_addr),
        .i_req_len     (b_req_len),
        .o_ar_valid    (b_ar_valid),
        .i_ar_ready    (b_ar_ready),
        .o_ar_addr     (b_ar_addr),
        .o_ar_len      (b_ar_len),
        .i_burst_done  (b_burst_done),
        .i_credit_ret  (b_credit_ret),
        .o_credits     (b_credits),
        .o_outstanding (b_outstanding),
        .o_busy        (b_busy)
    );

    typedef struct {
        logic [63:0]       addr;
        logic [31:0]       len;
        int                nb;
        logic [3:0][63:0]  a;
        logic [3:0][7:0]   l;
    } vec_t;

    vec_t vecs[6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ar(input string name);
        int k = 0;
        while (ar_valid !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        check({name, "_ar_valid"}, 64'(ar_valid), 64'd1);
    endtask

    task automatic take_ar(input string name, input logic [63:0] ea, input logic [7:0] el);
        wait_ar(name);
        check({name, "_addr"}, ar_addr, ea);
        check({name, "_len"}, 64'(ar_len), 64'(el));
        ar_ready = 1'b1;
        step();
        ar_ready = 1'b0;
        check({name, "_drop"}, 64'(ar_valid), 64'd0);
    endtask

    task automatic send_req(input logic [63:0] a, input logic [31:0] l);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        step();
        req_valid = 1'b0;
    endtask

    task automatic pulse_credits(input int n);
        credit_ret = 1'b1;
        repeat (n) step();
        credit_ret = 1'b0;
    endtask

    task automatic pulse_done(input int n);
        burst_done = 1'b1;
        repeat (n) step();
        burst_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 64'h1000, len: 40, nb: 3,
                    a: {64'h0, 64'h1080, 64'h1040, 64'h1000}, l: {8'd0, 8'd7, 8'd15, 8'd15}};
        vecs[1] = '{addr: 64'h1FF0, len: 16, nb: 2,
                    a: {64'h0, 64'h0, 64'h2000, 64'h1FF0}, l: {8'd0, 8'd0, 8'd11, 8'd3}};
        vecs[2] = '{addr: 64'h1003, len: 1, nb: 1,
                    a: {64'h0, 64'h0, 64'h0, 64'h1000}, l: {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[3] = '{addr: 64'hFFFF_FFFF_FFFF_FFC0, len: 20, nb: 2,
                    a: {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFC0},
                    l: {8'd0, 8'd0, 8'd3, 8'd15}};
        vecs[4] = '{addr: 64'h2F00, len: 64, nb: 4,
                    a: {64'h2FC0, 64'h2F80, 64'h2F40, 64'h2F00},
                    l: {8'd15, 8'd15, 8'd15, 8'd15}};
        vecs[5] = '{addr: 64'h3FFC, len: 2, nb: 2,
                    a: {64'h0, 64'h0, 64'h4000, 64'h3FFC}, l: {8'd0, 8'd0, 8'd0, 8'd0}};

        reset_n = 1'b0; clk_en = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_len = '0;
        ar_ready = 1'b0; burst_done = 1'b0; credit_ret = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_len = '0;
        b_ar_ready = 1'b0; b_burst_done = 1'b0; b_credit_ret = 1'b0;
        repeat (3) step();
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_ar_addr", ar_addr, 64'd0);
        check("rst_ar_len", 64'(ar_len), 64'd0);
        check("rst_credits", 64'(credits), 64'd32);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        step();
        check("post_rst_credits", 64'(credits), 64'd32);

        // Minimum latency: accepted in cycle N, ar_valid visible in N+3.
        send_req(64'h500, 32'd4);
        check("lat_n1_valid", 64'(ar_valid), 64'd0);
        check("lat_n1_busy", 64'(busy), 64'd1);
        check("lat_n1_ready", 64'(req_ready), 64'd0);
        step();
        check("lat_n2_valid", 64'(ar_valid), 64'd0);
        step();
        check("lat_n3_valid", 64'(ar_valid), 64'd1);
        take_ar("lat", 64'h500, 8'd3);
        pulse_credits(4);
        pulse_done(1);

        for (int i = 0; i < 6; i++) begin
            send_req(vecs[i].addr, vecs[i].len);
            for (int j = 0; j < vecs[i].nb; j++) begin
                take_ar($sformatf("vec%0d_b%0d", i, j), vecs[i].a[j], vecs[i].l[j]);
                pulse_credits(int'(vecs[i].l[j]) + 1);
                pulse_done(1);
            end
            step();
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_credits", i), 64'(credits), 64'd32);
            check($sformatf("vec%0d_outstanding", i), 64'(outstanding), 64'd0);
        end

        send_req(64'h800, 32'd0);
        check("len0_ready", 64'(req_ready), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        repeat (5) step();
        check("len0_no_ar", 64'(ar_valid), 64'd0);

        // Credit stall: two full bursts drain all credits; the third needs exactly 16 back.
        send_req(64'h0, 32'd48);
        take_ar("stall_b0", 64'h0, 8'd15);
        take_ar("stall_b1", 64'h40, 8'd15);
        check("stall_credits0", 64'(credits), 64'd0);
        check("stall_out2", 64'(outstanding), 64'd2);
        repeat (8) step();
        check("stall_hold", 64'(ar_valid), 64'd0);
        pulse_credits(15);
        check("stall_credits15", 64'(credits), 64'd15);
        check("stall_hold15", 64'(ar_valid), 64'd0);
        pulse_credits(1);
        check("stall_credits16", 64'(credits), 64'd16);
        check("stall_hold16", 64'(ar_valid), 64'd0);
        step();
        check("stall_release", 64'(ar_valid), 64'd1);
        take_ar("stall_b2", 64'h80, 8'd15);
        check("stall_busy", 64'(busy), 64'd0);
        pulse_credits(32);
        check("refill_credits", 64'(credits), 64'd32);
        pulse_credits(1);
        check("credit_saturate", 64'(credits), 64'd32);
        pulse_done(3);
        check("done_out0", 64'(outstanding), 64'd0);
        pulse_done(1);
        check("done_at_zero", 64'(outstanding), 64'd0);

        // Same-cycle combinations of issue, credit_ret and burst_done.
        send_req(64'h0, 32'd22);
        take_ar("sim_b0", 64'h0, 8'd15);
        take_ar("sim_b1", 64'h40, 8'd5);
        check("sim_credits10", 64'(credits), 64'd10);
        send_req(64'h100, 32'd4);
        wait_ar("sim_ret");
        ar_ready = 1'b1; credit_ret = 1'b1;
        step();
        ar_ready = 1'b0; credit_ret = 1'b0;
        check("sim_ret_credits", 64'(credits), 64'd7);
        check("sim_ret_out", 64'(outstanding), 64'd3);
        send_req(64'h200, 32'd4);
        wait_ar("sim_done");
        ar_ready = 1'b1; burst_done = 1'b1;
        step();
        ar_ready = 1'b0; burst_done = 1'b0;
        check("sim_done_out", 64'(outstanding), 64'd3);
        check("sim_done_credits", 64'(credits), 64'd3);
        pulse_credits(29);
        pulse_done(3);
        check("sim_restore_credits", 64'(credits), 64'd32);
        check("sim_restore_out", 64'(outstanding), 64'd0);

        // Outstanding cap on the MAX_OUTSTANDING=2, BURST_MAX=4 instance.
        b_req_valid = 1'b1; b_req_addr = 64'h0; b_req_len = 32'd12;
        step();
        b_req_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 50 && b_ar_valid !== 1'b1; k++) step();
            check($sformatf("cap_b%0d_valid", j), 64'(b_ar_valid), 64'd1);
            check($sformatf("cap_b%0d_addr", j), b_ar_addr, 64'(j * 16));
            check($sformatf("cap_b%0d_len", j), 64'(b_ar_len), 64'd3);
            b_ar_ready = 1'b1;
            step();
            b_ar_ready = 1'b0;
        end
        check("cap_out2", 64'(b_outstanding), 64'd2);
        check("cap_credits24", 64'(b_credits), 64'd24);
        repeat (6) step();
        check("cap_hold", 64'(b_ar_valid), 64'd0);
        b_burst_done = 1'b1;
        step();
        b_burst_done = 1'b0;
        check("cap_out1", 64'(b_outstanding), 64'd1);
        check("cap_not_yet", 64'(b_ar_valid), 64'd0);
        step();
        check("cap_release", 64'(b_ar_valid), 64'd1);
        check("cap_b2_addr", b_ar_addr, 64'h20);
        b_ar_ready = 1'b1; b_burst_done = 1'b1;
        step();
        b_ar_ready = 1'b0; b_burst_done = 1'b0;
        check("cap_hs_done_out", 64'(b_outstanding), 64'd1);
        check("cap_credits20", 64'(b_credits), 64'd20);
        check("cap_idle", 64'(b_busy), 64'd0);

        // clk_en low freezes everything; then reset mid-burst.
        send_req(64'h0, 32'd32);
        take_ar("rst_b0", 64'h0, 8'd15);
        wait_ar("rst_b1");
        check("rst_b1_credits", 64'(credits), 64'd16);
        clk_en = 1'b0; ar_ready = 1'b1; credit_ret = 1'b1; burst_done = 1'b1;
        repeat (3) step();
        check("cen_valid", 64'(ar_valid), 64'd1);
        check("cen_addr", ar_addr, 64'h40);
        check("cen_len", 64'(ar_len), 64'd15);
        check("cen_credits", 64'(credits), 64'd16);
        check("cen_out", 64'(outstanding), 64'd1);
        ar_ready = 1'b0; credit_ret = 1'b0; burst_done = 1'b0; clk_en = 1'b1;
        step();
        check("cen_resume_valid", 64'(ar_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(ar_valid), 64'd0);
        check("arst_credits", 64'(credits), 64'd32);
        check("arst_out", 64'(outstanding), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        check("arst_rel_credits", 64'(credits), 64'd32);
        check("arst_rel_out", 64'(outstanding), 64'd0);
        check("arst_rel_ready", 64'(req_ready), 64'd1);
        check("arst_rel_busy", 64'(busy), 64'd0);
        check("arst_rel_valid", 64'(ar_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
